// File: rtl/round_sequencer_pkg.sv
// Shared types and helpers for the game-round sequencer.
package round_pkg;

    localparam int DIGIT_W = 4;
    localparam int TIME_W  = 7;
    localparam logic [DIGIT_W-1:0] WILDCARD = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEED   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DRAW   = 3'd3,
        ST_PLAY   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic [TIME_W-1:0] sat_sub(input logic [TIME_W-1:0] a,
                                                  input logic [TIME_W-1:0] b);
        logic [TIME_W-1:0] res;
        if (a > b) begin
            res = a - b;
        end else begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/round_sequencer_sec_tick.sv
// Countdown prescaler: one-cycle tick after every TICK_DIV enabled cycles.
module sec_tick #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Enabled cycle counter, wraps at LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_tick = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller: seeds the digit generator once, draws filtered
// puzzles, runs the round countdown and keeps the score.
module round_sequencer
    import round_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int ROUND_SECS = 60,
    parameter int SETTLE     = 16,
    parameter int MAX_WILD   = 1,
    parameter int DRAW_MAX   = 64,
    parameter int SKIP_PEN   = 5,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_submit_ok,
    input  logic               i_skip,
    input  logic [DIGIT_W-1:0] i_rng_d0,
    input  logic [DIGIT_W-1:0] i_rng_d1,
    input  logic [DIGIT_W-1:0] i_rng_d2,
    input  logic [DIGIT_W-1:0] i_rng_d3,
    output logic               o_rng_seed_en,
    output logic [DIGIT_W-1:0] o_digit0,
    output logic [DIGIT_W-1:0] o_digit1,
    output logic [DIGIT_W-1:0] o_digit2,
    output logic [DIGIT_W-1:0] o_digit3,
    output logic               o_digits_valid,
    output logic [TIME_W-1:0]  o_time_left,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_game_over,
    output logic [2:0]         o_state
);

    localparam int SC_W = $clog2(SETTLE);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE - 1);
    localparam int DC_W = (DRAW_MAX > 1) ? $clog2(DRAW_MAX) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAW_MAX - 1);
    localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(ROUND_SECS);
    localparam logic [TIME_W-1:0] TIME_PEN  = TIME_W'(SKIP_PEN);

    state_t             r_state, w_state;
    logic               r_seeded, w_seeded;
    logic               r_seed_en, w_seed_en;
    logic [DIGIT_W-1:0] r_digit [4];
    logic [DIGIT_W-1:0] w_digit [4];
    logic               r_valid, w_valid;
    logic [TIME_W-1:0]  r_time, w_time, w_time_run;
    logic [SCORE_W-1:0] r_score, w_score;
    logic               r_game_over, w_game_over;
    logic [SC_W-1:0]    r_settle_cnt, w_settle_cnt;
    logic [DC_W-1:0]    r_draw_cnt, w_draw_cnt;

    logic [DIGIT_W-1:0] w_rng [4];
    logic [2:0]         w_wild_cnt;
    logic               w_invalid;
    logic               w_accept;
    logic               w_tick_en, w_tick_clr, w_tick;

    assign w_rng[0] = i_rng_d0;
    assign w_rng[1] = i_rng_d1;
    assign w_rng[2] = i_rng_d2;
    assign w_rng[3] = i_rng_d3;

    assign w_tick_en = (r_state == ST_DRAW) || (r_state == ST_PLAY);

    sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_tick_en),
        .i_clr  (w_tick_clr),
        .o_tick (w_tick)
    );

    // Draw filter: wildcard count and out-of-range detection on live digits
    always_comb begin
        w_wild_cnt = 3'd0;
        w_invalid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_rng[i] == WILDCARD) begin
                w_wild_cnt = w_wild_cnt + 3'd1;
            end else if (w_rng[i] > WILDCARD) begin
                w_invalid = 1'b1;
            end else begin
                w_invalid = w_invalid;
            end
        end
    end

    // A stubborn generator cannot stall the round: the last attempt always wins
    assign w_accept   = (!w_invalid && (w_wild_cnt <= 3'(MAX_WILD))) || (r_draw_cnt == DC_LAST);
    assign w_time_run = w_tick ? sat_sub(r_time, TIME_W'(1)) : r_time;

    // Next-state and next-output logic
    always_comb begin
        w_state      = r_state;
        w_seeded     = r_seeded;
        w_seed_en    = 1'b0;
        w_digit      = r_digit;
        w_valid      = r_valid;
        w_time       = r_time;
        w_score      = r_score;
        w_game_over  = r_game_over;
        w_settle_cnt = r_settle_cnt;
        w_draw_cnt   = r_draw_cnt;
        w_tick_clr   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_score      = '0;
                    w_time       = TIME_INIT;
                    w_tick_clr   = 1'b1;
                    w_game_over  = 1'b0;
                    w_settle_cnt = '0;
                    if (!r_seeded) begin
                        w_state   = ST_SEED;
                        w_seed_en = 1'b1;
                    end else begin
                        w_state = ST_SETTLE;
                    end
                end else begin
                    w_state = r_state;
                end
            end
            ST_SEED: begin
                w_seeded     = 1'b1;
                w_settle_cnt = '0;
                w_state      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_settle_cnt == SC_LAST) begin
                    w_draw_cnt = '0;
                    w_state    = ST_DRAW;
                end else begin
                    w_settle_cnt = r_settle_cnt + SC_W'(1);
                end
            end
            ST_DRAW: begin
                w_time = w_time_run;
                if (w_time_run == '0) begin
                    w_state     = ST_DONE;
                    w_game_over = 1'b1;
                    w_valid     = 1'b0;
                end else if (w_accept) begin
                    for (int k = 0; k < 4; k++) begin
                        w_digit[k] = (w_rng[k] > WILDCARD) ? WILDCARD : w_rng[k];
                    end
                    w_valid = 1'b1;
                    w_state = ST_PLAY;
                end else begin
                    w_draw_cnt = r_draw_cnt + DC_W'(1);
                end
            end
            ST_PLAY: begin
                if (i_submit_ok) begin
                    w_score    = (r_score == '1) ? r_score : r_score + SCORE_W'(1);
                    w_time     = w_time_run;
                    w_valid    = 1'b0;
                    w_draw_cnt = '0;
                    w_state    = ST_DRAW;
                end else if (i_skip) begin
                    w_time     = sat_sub(w_time_run, TIME_PEN);
                    w_valid    = 1'b0;
                    w_draw_cnt = '0;
                    w_state    = ST_DRAW;
                end else begin
                    w_time = w_time_run;
                end
                if (w_time == '0) begin
                    w_state     = ST_DONE;
                    w_game_over = 1'b1;
                    w_valid     = 1'b0;
                end else begin
                    w_game_over = r_game_over;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_seeded     <= 1'b0;
            r_seed_en    <= 1'b0;
            r_digit      <= '{default: '0};
            r_valid      <= 1'b0;
            r_time       <= TIME_INIT;
            r_score      <= '0;
            r_game_over  <= 1'b0;
            r_settle_cnt <= '0;
            r_draw_cnt   <= '0;
        end else begin
            r_state      <= w_state;
            r_seeded     <= w_seeded;
            r_seed_en    <= w_seed_en;
            r_digit      <= w_digit;
            r_valid      <= w_valid;
            r_time       <= w_time;
            r_score      <= w_score;
            r_game_over  <= w_game_over;
            r_settle_cnt <= w_settle_cnt;
            r_draw_cnt   <= w_draw_cnt;
        end
    end

    assign o_rng_seed_en  = r_seed_en;
    assign o_digit0       = r_digit[0];
    assign o_digit1       = r_digit[1];
    assign o_digit2       = r_digit[2];
    assign o_digit3       = r_digit[3];
    assign o_digits_valid = r_valid;
    assign o_time_left    = r_time;
    assign o_score        = r_score;
    assign o_game_over    = r_game_over;
    assign o_state        = r_state;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed self-checking bench for round_sequencer with a short round.
module tb_round_sequencer;

    logic       clk;
    logic       rst;
    logic       start, submit_ok, skip;
    logic [3:0] rd0, rd1, rd2, rd3;
    logic       seed_en;
    logic [3:0] dg0, dg1, dg2, dg3;
    logic       valid;
    logic [6:0] time_left;
    logic [7:0] score;
    logic       game_over;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    round_sequencer #(
        .TICK_DIV(4), .ROUND_SECS(3), .SETTLE(4), .MAX_WILD(1),
        .DRAW_MAX(8), .SKIP_PEN(1), .SCORE_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_start(start), .i_submit_ok(submit_ok), .i_skip(skip),
        .i_rng_d0(rd0), .i_rng_d1(rd1), .i_rng_d2(rd2), .i_rng_d3(rd3),
        .o_rng_seed_en(seed_en),
        .o_digit0(dg0), .o_digit1(dg1), .o_digit2(dg2), .o_digit3(dg3),
        .o_digits_valid(valid), .o_time_left(time_left), .o_score(score),
        .o_game_over(game_over), .o_state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rng(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        rd0 = a; rd1 = b; rd2 = c; rd3 = d;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_seed"}, 32'(seed_en), 32'd0);
        chk({tag, "_d0"}, 32'(dg0), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_time"}, 32'(time_left), 32'd3);
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_go"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; submit_ok = 1'b0; skip = 1'b0;
        set_rng(4'd1, 4'd2, 4'd3, 4'd4);
        cyc(2);
        chk_reset_vals("reset");
        rst = 1'b0;
        cyc(3);
        chk("idle_state", 32'(state), 32'd0);

        // Game 1: seed, first draw, two submits, timeout
        start = 1'b1; cyc(1); start = 1'b0;
        chk("g1_seed_hi", 32'(seed_en), 32'd1);
        chk("g1_state_seed", 32'(state), 32'd1);
        cyc(1);
        chk("g1_seed_lo", 32'(seed_en), 32'd0);
        chk("g1_state_settle", 32'(state), 32'd2);
        cyc(3);
        chk("g1_still_settle", 32'(state), 32'd2);
        cyc(1);
        chk("g1_state_draw", 32'(state), 32'd3);
        chk("g1_valid_pre", 32'(valid), 32'd0);
        cyc(1);
        chk("g1_valid", 32'(valid), 32'd1);
        chk("g1_digits", {16'd0, dg0, dg1, dg2, dg3}, 32'h1234);
        chk("g1_state_play", 32'(state), 32'd4);
        chk("g1_time0", 32'(time_left), 32'd3);
        submit_ok = 1'b1; cyc(1); submit_ok = 1'b0;
        chk("g1_score1", 32'(score), 32'd1);
        chk("g1_valid_drop1", 32'(valid), 32'd0);
        chk("g1_redraw", 32'(state), 32'd3);
        set_rng(4'd5, 4'd6, 4'd7, 4'd8);
        cyc(1);
        chk("g1_valid2", 32'(valid), 32'd1);
        chk("g1_digits2", {16'd0, dg0, dg1, dg2, dg3}, 32'h5678);
        cyc(1);
        chk("g1_time_tick", 32'(time_left), 32'd2);
        set_rng(4'd9, 4'd0, 4'd1, 4'd2);
        submit_ok = 1'b1; cyc(1); submit_ok = 1'b0;
        chk("g1_score2", 32'(score), 32'd2);
        chk("g1_valid_drop2", 32'(valid), 32'd0);
        cyc(1);
        chk("g1_digits3", {16'd0, dg0, dg1, dg2, dg3}, 32'h9012);
        chk("g1_valid3", 32'(valid), 32'd1);
        set_rng(4'd7, 4'd7, 4'd7, 4'd7);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("g1_digits_held", {16'd0, dg0, dg1, dg2, dg3}, 32'h9012);
        cyc(4);
        chk("g1_time_one", 32'(time_left), 32'd1);
        chk("g1_play_late", 32'(state), 32'd4);
        chk("g1_go_lo", 32'(game_over), 32'd0);
        cyc(1);
        chk("g1_time_zero", 32'(time_left), 32'd0);
        chk("g1_go_hi", 32'(game_over), 32'd1);
        chk("g1_state_done", 32'(state), 32'd5);
        chk("g1_valid_done", 32'(valid), 32'd0);
        chk("g1_score_held", 32'(score), 32'd2);
        chk("g1_digits_done", {16'd0, dg0, dg1, dg2, dg3}, 32'h9012);

        // Game 2: restart without seeding, wildcard rejection, submit+skip, skip to zero
        start = 1'b1; cyc(1); start = 1'b0;
        chk("g2_no_seed", 32'(seed_en), 32'd0);
        chk("g2_state_settle", 32'(state), 32'd2);
        chk("g2_score_clr", 32'(score), 32'd0);
        chk("g2_time_init", 32'(time_left), 32'd3);
        chk("g2_go_clr", 32'(game_over), 32'd0);
        set_rng(4'd10, 4'd10, 4'd3, 4'd4);
        cyc(4);
        chk("g2_state_draw", 32'(state), 32'd3);
        cyc(3);
        chk("g2_rejecting", 32'(state), 32'd3);
        chk("g2_valid_lo", 32'(valid), 32'd0);
        set_rng(4'd10, 4'd5, 4'd6, 4'd7);
        cyc(1);
        chk("g2_valid", 32'(valid), 32'd1);
        chk("g2_digits", {16'd0, dg0, dg1, dg2, dg3}, 32'hA567);
        chk("g2_time_tick", 32'(time_left), 32'd2);
        submit_ok = 1'b1; skip = 1'b1; cyc(1); submit_ok = 1'b0; skip = 1'b0;
        chk("g2_both_score", 32'(score), 32'd1);
        chk("g2_both_time", 32'(time_left), 32'd2);
        chk("g2_both_state", 32'(state), 32'd3);
        cyc(1);
        chk("g2_play", 32'(state), 32'd4);
        cyc(2);
        chk("g2_time_one", 32'(time_left), 32'd1);
        skip = 1'b1; cyc(1); skip = 1'b0;
        chk("g2_skip_time", 32'(time_left), 32'd0);
        chk("g2_skip_done", 32'(state), 32'd5);
        chk("g2_skip_go", 32'(game_over), 32'd1);
        chk("g2_skip_valid", 32'(valid), 32'd0);
        chk("g2_skip_score", 32'(score), 32'd1);

        // Game 3: filter bypass after DRAW_MAX attempts, invalid digit forced to wildcard
        set_rng(4'd12, 4'd10, 4'd10, 4'd10);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(11);
        chk("g3_still_draw", 32'(state), 32'd3);
        chk("g3_valid_lo", 32'(valid), 32'd0);
        cyc(1);
        chk("g3_valid", 32'(valid), 32'd1);
        chk("g3_digits", {16'd0, dg0, dg1, dg2, dg3}, 32'hAAAA);
        chk("g3_state_play", 32'(state), 32'd4);
        chk("g3_time", 32'(time_left), 32'd1);

        // Asynchronous reset mid-game, then a new start seeds again
        #2; rst = 1'b1; #1;
        chk_reset_vals("midrst");
        rst = 1'b0;
        cyc(2);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("rs_seed_hi", 32'(seed_en), 32'd1);
        chk("rs_state_seed", 32'(state), 32'd1);
        cyc(1);
        chk("rs_seed_lo", 32'(seed_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Game-round controller that sequences the 4-digit random generator. On the first start it seeds the generator once, then for each puzzle samples and freezes a set of four digits, rejecting draws with too many wildcards. It runs the round countdown, counts solved puzzles and draws a new puzzle on submit or skip. It sits between the debounced button inputs, the random generator and the display/scoring logic.

Parameters:
TICK_DIV, 100000000, clk cycles per countdown second
ROUND_SECS, 60, round length in seconds (1..127)
SETTLE, 16, cycles to wait after seeding before the first sample (>=2)
MAX_WILD, 1, max wildcard digits (value 10) accepted in a puzzle (0..4)
DRAW_MAX, 64, draw attempts before the filter is bypassed
SKIP_PEN, 5, seconds deducted on skip
SCORE_W, 8, score width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse, begin game
submit_ok  in  1  single-cycle pulse, current puzzle solved
skip  in  1  single-cycle pulse, abandon current puzzle
rng_d0..rng_d3  in  4 each  generator digits, 0-9 or 10 (wildcard); change every cycle
rng_seed_en  out  1  seed strobe to generator
digit0..digit3  out  4 each  frozen puzzle digits
digits_valid  out  1  puzzle digits valid
time_left  out  7  seconds remaining
score  out  SCORE_W  puzzles solved this game
game_over  out  1  level, round finished
state  out  3  current FSM state, for debug/display

Behaviour:
- Reset: state IDLE; rng_seed_en=0, digit0..3=0, digits_valid=0, time_left=ROUND_SECS, score=0, game_over=0; internal seeded_once=0, prescaler=0, draw counter=0.
- All outputs registered. Clock-domain-internal; no CDC.
- IDLE: start -> score=0, time_left=ROUND_SECS, prescaler=0; go SEED if !seeded_once, else SETTLE.
- SEED: rng_seed_en=1 for exactly this one cycle; seeded_once<=1; -> SETTLE. rng_seed_en is never asserted again until rst.
- SETTLE: count SETTLE cycles, then -> DRAW with draw counter=0.
- DRAW: each cycle count inputs equal to 10; any input >10 counts as invalid. If no invalid digit and wild count <= MAX_WILD, or draw counter == DRAW_MAX-1: latch rng_d0..3 into digit0..3 (inputs >10 forced to 10), digits_valid<=1, -> PLAY. Otherwise increment draw counter and resample next cycle.
- PLAY: digits held stable. submit_ok -> score+1 (saturates at all-ones), digits_valid<=0, -> DRAW. skip -> time_left -= SKIP_PEN (floors at 0), digits_valid<=0, -> DRAW; if the result is 0 -> DONE instead.
- Timer: prescaler runs only in DRAW and PLAY; wraps at TICK_DIV-1 and on the wrap decrements time_left (floor 0). time_left reaching 0 in DRAW or PLAY -> DONE next cycle.
- DONE: game_over=1, digits_valid=0, digits and score held. start -> game_over=0, then same as the IDLE start path.
- Simultaneous events: submit_ok and skip together -> submit only. submit_ok on the cycle time_left hits 0 -> score increments, then DONE. start outside IDLE/DONE is ignored. submit_ok/skip outside PLAY are ignored.
- Latency: start at cycle N -> rng_seed_en at N+1 -> first DRAW at N+2+SETTLE -> digits_valid at N+3+SETTLE at the earliest.
- Reset mid-game: immediate return to reset values. seeded_once clears, so the next start seeds again; this matches the generator, which also clears its seeded flag.

Decomposition:
- Package round_pkg: state enum (IDLE, SEED, SETTLE, DRAW, PLAY, DONE), WILDCARD=4'd10, DIGIT_W=4, TIME_W=7.
- Sub-module sec_tick: prescaler with enable and synchronous clear, emitting a one-cycle tick every TICK_DIV enabled cycles.
- Wildcard count/validity check stays inline as combinational logic.

Test Plan:
Use TICK_DIV=4, ROUND_SECS=3, SETTLE=4, MAX_WILD=1, DRAW_MAX=8, SKIP_PEN=1 unless noted.
- First start at cycle 10 -> rng_seed_en high only at cycle 11; digits_valid rises at cycle 17 when rng_d = 1,2,3,4; digit0..3=1,2,3,4.
- rng_d = 10,10,3,4 for 3 cycles, then 10,5,6,7 -> first draw rejected; latched 10,5,6,7, 3 attempts later than an immediate accept.
- rng_d held 10,10,10,10 -> accepted after 8 attempts; rng_d0=12 -> latched as 10.
- Two submit_ok pulses in PLAY -> score=2, digits_valid drops 1 cycle per submit; after 12 enabled cycles time_left=0, game_over=1.
- skip with time_left=1 -> time_left=0 and DONE without a draw; skip+submit_ok in the same cycle -> score+1, time_left unchanged.
- Second start from DONE -> no rng_seed_en pulse, score=0, time_left=3; rst in PLAY -> all outputs at reset values, next start pulses rng_seed_en.
